tcp_slow_path_send_q: RTL and testbench

Buffers slow-path response packets produced by the TCP RX datapath: SYN-ACK header, flow ID, source IP and destination IP. It presents them one at a time to the TX header assembly stage using a valid/ready handshake. The block decouples the RX control FSM from TX back-pressure, so the RX pipe can finish a new-flow setup in one cycle without waiting for the transmitter.

---
 rtl/tcp_slow_path_send_q.sv | 168 ++++++++++++++++
 tb/tb_tcp_slow_path_send_q.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tcp_slow_path_send_q.sv
// Slow-path TX send queue: buffers SYN-ACK responses
// (hdr, flow ID, IPs) for the TX header stage.
//
// Ports: clk, rst (async, active-high);
//   enqueue side  slow_path_send_pkt_enqueue_{val,pkt,flowid,src_ip,dst_ip,rdy};
//   dequeue side  slow_path_send_q_tx_{val,pkt,flowid,src_ip,dst_ip},
//                 tx_slow_path_send_q_rdy;
//   status        slow_path_send_q_occupancy,
//                 slow_path_send_q_drop_cnt (SLOW_PATH_SEND_Q_DROP_EN only).
// Macro SLOW_PATH_SEND_Q_DROP_EN: never back-pressure; drop when full.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tcp_pkg;
  localparam int FLOWID_W = 8;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] window;
  } tcp_pkt_hdr;

  typedef struct packed {
    tcp_pkt_hdr              pkt;
    logic [FLOWID_W-1:0]     flowid;
    logic [`IP_ADDR_W-1:0]   src_ip;
    logic [`IP_ADDR_W-1:0]   dst_ip;
  } send_q_entry_t;
endpackage

module tcp_slow_path_send_q
  import tcp_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slow_path_send_pkt_enqueue_val,
  input  tcp_pkt_hdr            slow_path_send_pkt_enqueue_pkt,
  input  logic [FLOWID_W-1:0]   slow_path_send_pkt_enqueue_flowid,
  input  logic [`IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_src_ip,
  input  logic [`IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_dst_ip,
  output logic                  slow_path_send_pkt_enqueue_rdy,
  output logic                  slow_path_send_q_tx_val,
  output tcp_pkt_hdr            slow_path_send_q_tx_pkt,
  output logic [FLOWID_W-1:0]   slow_path_send_q_tx_flowid,
  output logic [`IP_ADDR_W-1:0] slow_path_send_q_tx_src_ip,
  output logic [`IP_ADDR_W-1:0] slow_path_send_q_tx_dst_ip,
  input  logic                  tx_slow_path_send_q_rdy,
  output logic [DEPTH_W:0]      slow_path_send_q_occupancy
`ifdef SLOW_PATH_SEND_Q_DROP_EN
  ,
  output logic [31:0]           slow_path_send_q_drop_cnt
`endif
);

  send_q_entry_t        mem [DEPTH-1];
  send_q_entry_t        in_e;
  send_q_entry_t        out_q;
  logic [DEPTH_W-1:0]   wr_ptr;
  logic [DEPTH_W-1:0]   rd_ptr;
  logic [DEPTH_W-1:0]   ram_cnt;
  logic                 tx_val_q;
  logic [DEPTH_W:0]     occ_q;

  logic full;
  logic enq;
  logic deq;
  logic load;
  logic ram_ne;
  logic ram_rd;
  logic byp;
  logic ram_wr;

  // RAM holds DEPTH-1 entries, so pointers wrap at DEPTH-2.
  function automatic logic [DEPTH_W-1:0] nxt(
    input logic [DEPTH_W-1:0] p
  );
    return (p == DEPTH_W'(DEPTH-2)) ? '0 : p + 1'b1;
  endfunction

  assign in_e = '{
    pkt:    slow_path_send_pkt_enqueue_pkt,
    flowid: slow_path_send_pkt_enqueue_flowid,
    src_ip: slow_path_send_pkt_enqueue_src_ip,
    dst_ip: slow_path_send_pkt_enqueue_dst_ip
  };

  assign full = (occ_q == (DEPTH_W+1)'(DEPTH));

`ifdef SLOW_PATH_SEND_Q_DROP_EN
  assign slow_path_send_pkt_enqueue_rdy = 1'b1;
`else
  assign slow_path_send_pkt_enqueue_rdy = !full;
`endif

  // A full queue never accepts, in either build.
  assign enq    = slow_path_send_pkt_enqueue_val && !full;
  assign deq    = tx_val_q && tx_slow_path_send_q_rdy;
  assign load   = !tx_val_q || deq;
  assign ram_ne = (ram_cnt != '0);
  assign ram_rd = load && ram_ne;
  assign byp    = load && !ram_ne && enq;
  assign ram_wr = enq && !byp;

  always_ff @(posedge clk) begin
    if (ram_wr)
      mem[wr_ptr] <= in_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      out_q    <= '0;
      tx_val_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (ram_wr)
        wr_ptr <= nxt(wr_ptr);
      if (ram_rd)
        rd_ptr <= nxt(rd_ptr);
      ram_cnt <= ram_cnt + DEPTH_W'(ram_wr)
                         - DEPTH_W'(ram_rd);
      if (ram_rd) begin
        out_q    <= mem[rd_ptr];
        tx_val_q <= 1'b1;
      end else if (byp) begin
        out_q    <= in_e;
        tx_val_q <= 1'b1;
      end else if (deq) begin
        tx_val_q <= 1'b0;
      end
      if (enq && !deq)
        occ_q <= occ_q + 1'b1;
      else if (deq && !enq)
        occ_q <= occ_q - 1'b1;
    end
  end

`ifdef SLOW_PATH_SEND_Q_DROP_EN
  logic [31:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= '0;
    else if (slow_path_send_pkt_enqueue_val && full
             && drop_q != 32'hFFFF_FFFF)
      drop_q <= drop_q + 1'b1;
  end

  assign slow_path_send_q_drop_cnt = drop_q;
`endif

  assign slow_path_send_q_tx_val    = tx_val_q;
  assign slow_path_send_q_tx_pkt    = out_q.pkt;
  assign slow_path_send_q_tx_flowid = out_q.flowid;
  assign slow_path_send_q_tx_src_ip = out_q.src_ip;
  assign slow_path_send_q_tx_dst_ip = out_q.dst_ip;
  assign slow_path_send_q_occupancy = occ_q;

endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// Directed bench for tcp_slow_path_send_q.
// Build with SLOW_PATH_SEND_Q_DROP_EN to cover drop mode.
module tb_tcp_slow_path_send_q;
  import tcp_pkg::*;

  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  val = 1'b0;
  tcp_pkt_hdr            pkt = '0;
  logic [FLOWID_W-1:0]   fid = '0;
  logic [`IP_ADDR_W-1:0] sip = '0;
  logic [`IP_ADDR_W-1:0] dip = '0;
  logic                  enq_rdy;
  logic                  tx_val;
  tcp_pkt_hdr            tx_pkt;
  logic [FLOWID_W-1:0]   tx_fid;
  logic [`IP_ADDR_W-1:0] tx_sip;
  logic [`IP_ADDR_W-1:0] tx_dip;
  logic                  tx_rdy = 1'b0;
  logic [3:0]            occ;
`ifdef SLOW_PATH_SEND_Q_DROP_EN
  logic [31:0]           drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcp_slow_path_send_q #(.DEPTH(DEPTH)) dut (
    .clk                               (clk),
    .rst                               (rst),
    .slow_path_send_pkt_enqueue_val    (val),
    .slow_path_send_pkt_enqueue_pkt    (pkt),
    .slow_path_send_pkt_enqueue_flowid (fid),
    .slow_path_send_pkt_enqueue_src_ip (sip),
    .slow_path_send_pkt_enqueue_dst_ip (dip),
    .slow_path_send_pkt_enqueue_rdy    (enq_rdy),
    .slow_path_send_q_tx_val           (tx_val),
    .slow_path_send_q_tx_pkt           (tx_pkt),
    .slow_path_send_q_tx_flowid        (tx_fid),
    .slow_path_send_q_tx_src_ip        (tx_sip),
    .slow_path_send_q_tx_dst_ip        (tx_dip),
    .tx_slow_path_send_q_rdy           (tx_rdy),
    .slow_path_send_q_occupancy        (occ)
`ifdef SLOW_PATH_SEND_Q_DROP_EN
    ,
    .slow_path_send_q_drop_cnt         (drop_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic tcp_pkt_hdr synack();
    tcp_pkt_hdr h;
    h = '0;
    h.src_port = 16'd80;
    h.dst_port = 16'd5555;
    h.seq_num  = 32'h0000_00FF;
    h.ack_num  = 32'h0000_1001;
    h.flags    = 8'h12;
    h.window   = 16'hFFFF;
    return h;
  endfunction

  task automatic fill(input int n, input int base);
    tx_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      val = 1'b1;
      fid = FLOWID_W'(base + i);
      sip = 32'h0A00_0100 + i;
      cyc();
    end
    val = 1'b0;
  endtask

  task automatic drain(input string tag,
                       input int n, input int base);
    tx_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_val"}, tx_val, 1'b1);
      chk({tag, "_fid"}, tx_fid, FLOWID_W'(base + i));
      cyc();
    end
    chk({tag, "_empty"}, tx_val, 1'b0);
    chk({tag, "_occ0"}, occ, 4'd0);
    tx_rdy = 1'b0;
  endtask

  task automatic bypass_one(input string tag);
    val    = 1'b1;
    pkt    = synack();
    fid    = 8'd3;
    sip    = 32'h0A00_0001;
    dip    = 32'h0A00_0002;
    tx_rdy = 1'b1;
    cyc();
    val = 1'b0;
    chk({tag, "_val"}, tx_val, 1'b1);
    chk({tag, "_pkt"}, tx_pkt, synack());
    chk({tag, "_fid"}, tx_fid, 8'd3);
    chk({tag, "_sip"}, tx_sip, 32'h0A00_0001);
    chk({tag, "_dip"}, tx_dip, 32'h0A00_0002);
    chk({tag, "_occ1"}, occ, 4'd1);
    cyc();
    chk({tag, "_val0"}, tx_val, 1'b0);
    chk({tag, "_occ0"}, occ, 4'd0);
    tx_rdy = 1'b0;
  endtask

  logic [FLOWID_W-1:0] sb [$];
  int sent;
  int rcvd;

  initial begin
    repeat (2) cyc();
    chk("rst_val", tx_val, 1'b0);
    chk("rst_rdy", enq_rdy, 1'b1);
    chk("rst_occ", occ, 4'd0);
    chk("rst_fid", tx_fid, 8'd0);
    rst = 1'b0;
    cyc();

    bypass_one("byp");

    fill(DEPTH, 0);
    chk("full_occ", occ, 4'd8);
`ifdef SLOW_PATH_SEND_Q_DROP_EN
    chk("full_rdy", enq_rdy, 1'b1);
`else
    chk("full_rdy", enq_rdy, 1'b0);
`endif
    drain("full", DEPTH, 0);

    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 400 && rcvd < 20; c++) begin
      val    = (sent < 20) && ($urandom_range(0, 3) != 0);
      fid    = FLOWID_W'(8'h40 + sent);
      sip    = 32'hC0A8_0000 + sent;
      tx_rdy = ($urandom_range(0, 2) == 0);
      chk("wrap_occ", occ, sb.size());
      chk("wrap_max", occ <= 4'd8, 1'b1);
      if (tx_val && tx_rdy) begin
        chk("wrap_ord", tx_fid, sb[0]);
        void'(sb.pop_front());
        rcvd++;
      end
      if (val && enq_rdy) begin
        sb.push_back(fid);
        sent++;
      end
      cyc();
    end
    val    = 1'b0;
    tx_rdy = 1'b0;
    chk("wrap_done", rcvd, 20);
    chk("wrap_empty", tx_val, 1'b0);

    val = 1'b1;
    fid = 8'd5;
    cyc();
    chk("sim_occ1", occ, 4'd1);
    chk("sim_fid5", tx_fid, 8'd5);
    fid    = 8'd6;
    tx_rdy = 1'b1;
    cyc();
    val    = 1'b0;
    tx_rdy = 1'b0;
    chk("sim_val", tx_val, 1'b1);
    chk("sim_fid6", tx_fid, 8'd6);
    chk("sim_occ", occ, 4'd1);
    drain("sim_drain", 1, 6);

`ifdef SLOW_PATH_SEND_Q_DROP_EN
    fill(DEPTH, 8'h20);
    fill(3, 8'h80);
    chk("drop_cnt", drop_cnt, 32'd3);
    chk("drop_occ", occ, 4'd8);
    drain("drop", DEPTH, 8'h20);
`endif

    fill(5, 8'h50);
    chk("ar_occ5", occ, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_val", tx_val, 1'b0);
    chk("ar_occ", occ, 4'd0);
    chk("ar_rdy", enq_rdy, 1'b1);
`ifdef SLOW_PATH_SEND_Q_DROP_EN
    chk("ar_drop", drop_cnt, 32'd0);
`endif
    #1;
    rst = 1'b0;
    bypass_one("ar_byp");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
